// File: rtl/led_flow_pkg.sv
// Shared types and constants for the flowing-light scheduler.
package led_flow_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
  typedef enum logic [1:0] {ROT_R, ROT_L, BOUNCE, BLINK} mode_e;

  localparam logic [15:0] SEED_R   = 16'h8000;
  localparam logic [15:0] SEED_L   = 16'h0001;
  localparam logic [15:0] BLINK_ON = 16'hFFFF;

  function automatic logic [15:0] seed_of(mode_e m);
    case (m)
      ROT_L:   return SEED_L;
      BLINK:   return BLINK_ON;
      default: return SEED_R;
    endcase
  endfunction

endpackage

// File: rtl/led_flow_tick_gen.sv
// Step prescaler: counts while enabled and fires a one-cycle tick at
// (TICK_DIV >> speed) - 1. The limit is combinational so speed changes apply at once.
module led_flow_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);
  localparam int CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   limit;

  assign limit = (32'(TICK_DIV) >> speed) - 32'd1;
  // >= rather than == so a lowered limit below cnt still fires next edge
  assign tick  = en && ({{(32-CW){1'b0}}, cnt} >= limit);

  always_ff @(posedge clk) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/led_flow_scheduler.sv
// 16-LED flowing-light sequencer: IDLE/RUN/PAUSE control, pattern register, mode tracking.
// LED_FLOW_BOUNCE_EN enables the bounce pattern for mode 2; otherwise mode 2 rotates right.
import led_flow_pkg::*;

module led_flow_scheduler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic [1:0]  mode,
  input  logic [1:0]  speed,
  output logic [15:0] led,
  output logic        busy
);
  state_e      state, state_nx;
  mode_e       mode_q, mode_nx, mode_in;
  logic [15:0] led_nx;
  logic        mchg, en, clr, tick, load, step;
`ifdef LED_FLOW_BOUNCE_EN
  logic        dir, dir_nx;   // 0 = moving right, 1 = moving left
`endif

  assign mode_in = mode_e'(mode);
  assign mchg    = (mode_in != mode_q);
  assign busy    = (state != IDLE);

  // counting is suppressed on any edge that stops, pauses or reloads
  assign en  = (state == RUN) && !stop && !pause && !mchg;
  assign clr = stop || ((state == IDLE) && start) || ((state != IDLE) && mchg);

  led_flow_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .speed (speed),
    .tick  (tick)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    if (stop) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            state_nx = RUN;
            load     = 1'b1;
          end
        RUN:
          if (mchg) begin
            load = 1'b1;
            if (pause) state_nx = PAUSE;
          end else if (pause) begin
            state_nx = PAUSE;
          end else begin
            step = tick;
          end
        PAUSE:
          if (mchg) begin
            load = 1'b1;
            if (start) state_nx = RUN;
          end else if (start) begin
            state_nx = RUN;
          end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    led_nx  = led;
    mode_nx = mode_q;
`ifdef LED_FLOW_BOUNCE_EN
    dir_nx  = dir;
`endif
    if (stop) begin
      led_nx = '0;
    end else if (load) begin
      led_nx  = seed_of(mode_in);
      mode_nx = mode_in;
`ifdef LED_FLOW_BOUNCE_EN
      dir_nx  = 1'b0;
`endif
    end else if (step) begin
      case (mode_q)
        ROT_L: led_nx = {led[14:0], led[15]};
        BLINK: led_nx = ~led;
`ifdef LED_FLOW_BOUNCE_EN
        BOUNCE:
          if (dir) begin
            led_nx = led << 1;
            if (led_nx == SEED_R) dir_nx = 1'b0;
          end else begin
            led_nx = led >> 1;
            if (led_nx == SEED_L) dir_nx = 1'b1;
          end
`endif
        default: led_nx = {led[0], led[15:1]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      led    <= '0;
      mode_q <= ROT_R;
`ifdef LED_FLOW_BOUNCE_EN
      dir    <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      led    <= led_nx;
      mode_q <= mode_nx;
`ifdef LED_FLOW_BOUNCE_EN
      dir    <= dir_nx;
`endif
    end
  end

endmodule

// File: tb/tb_led_flow_scheduler.sv
// Bench for led_flow_scheduler: phase-based reference model, per-cycle compare, directed + random stimulus.
module tb_led_flow_scheduler;
  localparam int TD = 10;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'd0, speed = 2'd0;
  logic [15:0] led;
  logic busy;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  // model: state 0 idle / 1 run / 2 pause; the pattern is a function of (mode, step count)
  int ms = 0, mq = 0, ph = 0, mc = 0;

  led_flow_scheduler #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .mode(mode), .speed(speed), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(int m_in, int p_in);
    int m;
    int p;
    m = m_in;
`ifndef LED_FLOW_BOUNCE_EN
    if (m == 2) m = 0;
`endif
    case (m)
      0: return 16'h8000 >> (p_in % 16);
      1: return 16'h0001 << (p_in % 16);
      2: begin
        p = p_in % 30;
        return (p < 15) ? (16'h8000 >> p) : (16'h0001 << (p - 15));
      end
      default: return (p_in % 2) ? 16'h0000 : 16'hFFFF;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int lim;
    lim = (TD >> speed) - 1;
    if (!rst) begin
      ms = 0; mq = 0; ph = 0; mc = 0;
    end else if (stop) begin
      ms = 0; ph = 0; mc = 0;
    end else if (ms == 0) begin
      if (start) begin ms = 1; mq = int'(mode); ph = 0; mc = 0; end
    end else if (int'(mode) != mq) begin
      mq = int'(mode); ph = 0; mc = 0;
      if (ms == 1 && pause) ms = 2;
      else if (ms == 2 && start) ms = 1;
    end else if (ms == 1) begin
      if (pause) ms = 2;
      else if (mc >= lim) begin mc = 0; ph++; end
      else mc++;
    end else if (start) begin
      ms = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("led", {16'h0, led}, {16'h0, (ms == 0) ? 16'h0000 : pat(mq, ph)});
      chk("busy", {31'h0, busy}, {31'h0, ms != 0});
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(logic [1:0] m, logic [1:0] s);
    mode = m; speed = s; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  initial begin
    cyc(1);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    chk_en = 1'b1;
    cyc(50);
    chk("idle_led", {16'h0, led}, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    // rotate-right, 10-cycle steps
    go(2'd0, 2'd0);
    chk("seed0", {16'h0, led}, 32'h8000);
    chk("run_busy", {31'h0, busy}, 32'h1);
    cyc(10);  chk("step1", {16'h0, led}, 32'h4000);
    cyc(140); chk("step15", {16'h0, led}, 32'h0001);
    cyc(10);  chk("wrap", {16'h0, led}, 32'h8000);
    halt();
    chk("stop_led", {16'h0, led}, 32'h0);
    chk("stop_busy", {31'h0, busy}, 32'h0);

    // mode switch mid-run at 0400
    go(2'd0, 2'd0);
    cyc(50);  chk("at0400", {16'h0, led}, 32'h0400);
    mode = 2'd1;
    cyc(1);   chk("reload1", {16'h0, led}, 32'h0001);
    cyc(9);   chk("no_step_yet", {16'h0, led}, 32'h0001);
    cyc(1);   chk("step_0002", {16'h0, led}, 32'h0002);

    // stop wins over start
    stop = 1'b1; start = 1'b1;
    cyc(1);
    stop = 1'b0; start = 1'b0;
    chk("stopstart_led", {16'h0, led}, 32'h0);
    chk("stopstart_busy", {31'h0, busy}, 32'h0);

    // speed 0 -> 3 at cnt=7
    go(2'd0, 2'd0);
    cyc(7);
    speed = 2'd3;
    cyc(1);   chk("speed_up", {16'h0, led}, 32'h4000);
    halt();

    // bounce (or rotate-right without the feature) at one step per cycle
    go(2'd2, 2'd3);
    chk("b_seed", {16'h0, led}, 32'h8000);
    cyc(15);  chk("b_15", {16'h0, led}, 32'h0001);
`ifdef LED_FLOW_BOUNCE_EN
    cyc(1);   chk("b_16", {16'h0, led}, 32'h0002);
    cyc(13);  chk("b_29", {16'h0, led}, 32'h4000);
    cyc(1);   chk("b_30", {16'h0, led}, 32'h8000);
`else
    cyc(1);   chk("b_16", {16'h0, led}, 32'h8000);
    cyc(13);  chk("b_29", {16'h0, led}, 32'h0004);
    cyc(1);   chk("b_30", {16'h0, led}, 32'h0002);
`endif
    halt();

    // blink with pause/resume
    go(2'd3, 2'd1);
    chk("bl_seed", {16'h0, led}, 32'hFFFF);
    cyc(5);   chk("bl_1", {16'h0, led}, 32'h0000);
    cyc(5);   chk("bl_2", {16'h0, led}, 32'hFFFF);
    cyc(5);   chk("bl_3", {16'h0, led}, 32'h0000);
    cyc(2);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    chk("paused_busy", {31'h0, busy}, 32'h1);
    cyc(20);  chk("frozen", {16'h0, led}, 32'h0000);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);   chk("resume_hold", {16'h0, led}, 32'h0000);
    cyc(1);   chk("resume_step", {16'h0, led}, 32'hFFFF);
    halt();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 14) == 0);
      pause = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) speed = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 399) != 0);
      cyc(1);
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0; rst = 1'b1;
    cyc(2);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_flow_scheduler.md
# led_flow_scheduler

Sequencing controller for the 16-LED flowing-light display. Owns the tick prescaler and the pattern register, and turns start/pause/stop pulses plus mode and speed selects into a 16-bit LED drive. Sits between the board switches/buttons (already synchronised and debounced upstream) and the LED pins.

## Interface
- TICK_DIV, default 100_000_000: base tick period in clk cycles at speed 0. Benches set 10.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse. From IDLE it begins a run; from PAUSE it resumes.
- pause  input  1  one-cycle pulse. From RUN it freezes the display.
- stop  input  1  one-cycle pulse. Returns to IDLE from any state.
- mode  input  2  pattern select: 0 rotate-right, 1 rotate-left, 2 bounce, 3 blink.
- speed  input  2  step period = TICK_DIV >> speed cycles.
- led  output  16  LED drive; bit 15 is the leftmost LED.
- busy  output  1  high in RUN or PAUSE.

## Operation
- Reset values: state IDLE, led 16'h0000, busy 0, cnt 0, dir right, mode_q 0.
- Three states: IDLE, RUN, PAUSE.
- Control priority is stop > start > pause. Pulses that do not apply to the current state are ignored.
- Transitions:
  - IDLE + start → RUN: load the pattern seed for the current mode, cnt=0, mode_q=mode.
  - RUN + pause → PAUSE: cnt and led held.
  - PAUSE + start → RUN: resume with cnt unchanged.
  - Any state + stop → IDLE: led=0, cnt=0.
- Seeds: mode0 16'h8000; mode1 16'h0001; mode2 16'h8000 with dir=right; mode3 16'hFFFF.
- Step rules, applied on a tick:
  - mode0: shift right; 16'h0001 wraps to 16'h8000.
  - mode1: shift left; 16'h8000 wraps to 16'h0001.
  - mode2: shift toward dir. On reaching 16'h0001, dir becomes left; on reaching 16'h8000, dir becomes right. Endpoints are shown once per pass, so a full cycle is 30 ticks.
  - mode3: led = ~led.
- Mode change in RUN or PAUSE (mode != mode_q): on the next edge, reload the seed, set cnt=0 and update mode_q. No step occurs on that edge. The state is unchanged.
- led is always exactly one-hot in modes 0–2, and all-ones or all-zeros in mode 3.

## Timing
- limit = (TICK_DIV >> speed) − 1. It is computed combinationally, so speed changes take effect immediately.
- In RUN, cnt increments every cycle. When cnt >= limit, a tick fires, cnt←0 and led steps on the same edge.
- Step period is limit+1 cycles. With TICK_DIV=10: 10, 5, 2 and 1 cycles for speed 0–3.
- Speed lowered while cnt > new limit: the tick fires on the next edge, with no overflow and no lost step.
- start → first seed visible: 1 cycle. First step occurs limit+1 cycles after the seed appears.
- pause takes effect on the next edge; no step occurs on that edge even if a tick was due.
- stop → led=0 and busy=0 on the next edge.
- Reset mid-run has the same effect as power-on reset on the next edge.

## Configuration
- LED_FLOW_BOUNCE_EN defined: mode 2 is bounce, as specified above.
- LED_FLOW_BOUNCE_EN undefined: the dir register and bounce logic are removed, and mode 2 behaves exactly as mode 0 (seed 16'h8000, rotate-right).

## Structure
- Package led_flow_pkg holds:
  - state enum: IDLE, RUN, PAUSE;
  - mode enum: ROT_R, ROT_L, BOUNCE, BLINK;
  - seed constants: SEED_R=16'h8000, SEED_L=16'h0001, BLINK_ON=16'hFFFF.
- Sub-module led_flow_tick_gen takes TICK_DIV, clk, rst, en, speed and produces a one-cycle tick; it contains cnt and the limit compare. en is high only in RUN.
- The top level holds the FSM, the pattern register, dir and mode_q.

## Test plan
All scenarios use TICK_DIV=10.
- Reset, then stay idle 50 cycles → led=0 and busy=0 throughout.
- mode=0, speed=0, start → led 8000 one cycle later, then 4000 after 10 cycles, continuing to 0001 and wrapping to 8000 after 16 steps.
- mode=2 (macro defined), speed=3 → led sequence 8000…0001,0002…8000,4000, one step per cycle, with 0001 and 8000 each held for one step only. With the macro undefined, the same stimulus gives the rotate-right sequence.
- mode=3, speed=1, start; pause after 3 steps; hold 20 cycles; start → led toggles FFFF/0000 every 5 cycles, is frozen during pause, and resumes with the remaining count preserved.
- Mode switch from 0 to 1 mid-run with led=16'h0400 → next edge led=0001 and cnt=0; the next step is 0002 after 10 cycles.
- Simultaneous stop+start in RUN → IDLE with led=0. Switching speed from 0 to 3 at cnt=7 → step on the next edge.
